// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-ported data memory: MEM stage has priority, loader is starvation-bounded.
// Latency: grant cycle + MEM_LAT strobe cycles + 1 response cycle; the pipeline is stalled until its response cycle.
module dmem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LAT      = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pipe_re,
    input  logic              pipe_we,
    input  logic [ADDR_W-1:0] pipe_addr,
    input  logic [DATA_W-1:0] pipe_wdata,
    output logic              pipe_stall,
    output logic              pipe_done,
    output logic [DATA_W-1:0] pipe_rdata,
    input  logic              dbg_valid,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ready,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    typedef enum logic {OWN_PIPE, OWN_DBG} owner_t;

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        lat_q, lat_d;
    logic [3:0]        starve_q, starve_d;
    logic [DATA_W-1:0] pipe_rdata_q, dbg_rdata_q;

    logic pipe_req, starve_hit, grant_pipe, grant_dbg, capture;

    assign pipe_req   = pipe_re | pipe_we;
    assign starve_hit = dbg_valid && (starve_q >= 4'(STARVE_LIMIT));
    assign grant_pipe = (state_q == IDLE) && pipe_req && !starve_hit;
    assign grant_dbg  = (state_q == IDLE) && !grant_pipe && dbg_valid;
    assign capture    = (state_q == BUSY) && (lat_q == 4'd0) && !we_q;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        lat_d    = lat_q;
        starve_d = starve_q;
        case (state_q)
            IDLE: begin
                if (grant_pipe) begin
                    state_d = BUSY;
                    owner_d = OWN_PIPE;
                    we_d    = pipe_we;
                    addr_d  = pipe_addr;
                    wdata_d = pipe_wdata;
                    lat_d   = 4'(MEM_LAT - 1);
                    if (dbg_valid)
                        starve_d = (starve_q == 4'd15) ? 4'd15 : starve_q + 4'd1;
                    else
                        starve_d = 4'd0;
                end else if (grant_dbg) begin
                    state_d  = BUSY;
                    owner_d  = OWN_DBG;
                    we_d     = dbg_we;
                    addr_d   = dbg_addr;
                    wdata_d  = dbg_wdata;
                    lat_d    = 4'(MEM_LAT - 1);
                    starve_d = 4'd0;
                end else begin
                    // No grant in IDLE implies the loader is not asking.
                    starve_d = 4'd0;
                end
            end
            BUSY: begin
                if (lat_q == 4'd0)
                    state_d = RESP;
                else
                    lat_d = lat_q - 4'd1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            owner_q  <= OWN_PIPE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            lat_q    <= 4'd0;
            starve_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            lat_q    <= lat_d;
            starve_q <= starve_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_rdata_q <= '0;
            dbg_rdata_q  <= '0;
        end else if (capture) begin
            if (owner_q == OWN_PIPE)
                pipe_rdata_q <= mem_rdata;
            else
                dbg_rdata_q  <= mem_rdata;
        end
    end

    // Combinational outputs are gated by rst_n so everything reads 0 while reset is held.
    assign pipe_stall = rst_n && pipe_req && !((state_q == RESP) && (owner_q == OWN_PIPE));
    assign dbg_ready  = rst_n && grant_dbg;
    assign pipe_done  = (state_q == RESP) && (owner_q == OWN_PIPE);
    assign dbg_rvalid = (state_q == RESP) && (owner_q == OWN_DBG);
    assign pipe_rdata = pipe_rdata_q;
    assign dbg_rdata  = dbg_rdata_q;
    assign mem_re     = (state_q == BUSY) && !we_q;
    assign mem_we     = (state_q == BUSY) && we_q;
    assign mem_addr   = (state_q == BUSY) ? addr_q  : '0;
    assign mem_wdata  = (state_q == BUSY) ? wdata_q : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: main instance (MEM_LAT=2, STARVE_LIMIT=4) on a memory model, plus MEM_LAT=1/15 instances.
module tb_dmem_arbiter;

    localparam int LAT = 2;

    logic        clk, rst_n;
    logic        pipe_re, pipe_we;
    logic [31:0] pipe_addr, pipe_wdata;
    logic        dbg_valid, dbg_we;
    logic [31:0] dbg_addr, dbg_wdata;

    logic        pipe_stall, pipe_done, dbg_ready, dbg_rvalid, mem_re, mem_we;
    logic [31:0] pipe_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;

    logic        l1_stall, l1_done, l1_dready, l1_rvalid, l1_mem_re, l1_mem_we;
    logic [31:0] l1_rdata, l1_drdata, l1_mem_addr, l1_mem_wdata;
    logic        l15_stall, l15_done, l15_dready, l15_rvalid, l15_mem_re, l15_mem_we;
    logic [31:0] l15_rdata, l15_drdata, l15_mem_addr, l15_mem_wdata;

    logic [31:0] mem    [0:63];
    logic [31:0] shadow [0:63];
    logic [31:0] pipe_exp_q[$];
    logic [31:0] dbg_exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_LIMIT(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .pipe_re(pipe_re), .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_wdata(pipe_wdata),
        .pipe_stall(pipe_stall), .pipe_done(pipe_done), .pipe_rdata(pipe_rdata),
        .dbg_valid(dbg_valid), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ready(dbg_ready), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_LIMIT(4)) u_lat1 (
        .clk(clk), .rst_n(rst_n),
        .pipe_re(pipe_re), .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_wdata(pipe_wdata),
        .pipe_stall(l1_stall), .pipe_done(l1_done), .pipe_rdata(l1_rdata),
        .dbg_valid(1'b0), .dbg_we(1'b0), .dbg_addr(32'd0), .dbg_wdata(32'd0),
        .dbg_ready(l1_dready), .dbg_rvalid(l1_rvalid), .dbg_rdata(l1_drdata),
        .mem_re(l1_mem_re), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata),
        .mem_rdata(~l1_mem_addr)
    );

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(15), .STARVE_LIMIT(4)) u_lat15 (
        .clk(clk), .rst_n(rst_n),
        .pipe_re(pipe_re), .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_wdata(pipe_wdata),
        .pipe_stall(l15_stall), .pipe_done(l15_done), .pipe_rdata(l15_rdata),
        .dbg_valid(1'b0), .dbg_we(1'b0), .dbg_addr(32'd0), .dbg_wdata(32'd0),
        .dbg_ready(l15_dready), .dbg_rvalid(l15_rvalid), .dbg_rdata(l15_drdata),
        .mem_re(l15_mem_re), .mem_we(l15_mem_we), .mem_addr(l15_mem_addr), .mem_wdata(l15_mem_wdata),
        .mem_rdata(~l15_mem_addr)
    );

    // Single-port memory array behind the main instance; reads are combinational.
    always @(posedge clk) if (mem_we) mem[mem_addr[5:0]] <= mem_wdata;
    assign mem_rdata = mem[mem_addr[5:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pipe_re = 1'b1; dbg_valid = 1'b1;
        repeat (2) cyc();
        @(negedge clk);
        n_checks++;
        if ({pipe_stall, pipe_done, dbg_ready, dbg_rvalid, mem_re, mem_we} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {pipe_stall, pipe_done, dbg_ready, dbg_rvalid, mem_re, mem_we});
        end
        n_checks++;
        if (pipe_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_pipe_rdata: got %h expected 0", pipe_rdata); end
        n_checks++;
        if (dbg_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_dbg_rdata: got %h expected 0", dbg_rdata); end
        n_checks++;
        if ({mem_addr, mem_wdata} !== 64'h0) begin
            n_fail++; $display("FAIL reset_mem_bus: got %h/%h expected 0/0", mem_addr, mem_wdata);
        end
        pipe_re = 1'b0; dbg_valid = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_dbg_write();
        dbg_valid = 1'b1; dbg_we = 1'b1; dbg_addr = 32'd3; dbg_wdata = 32'h8C123456;
        @(negedge clk);
        n_checks++;
        if ({dbg_ready, pipe_stall} !== 2'b10) begin
            n_fail++; $display("FAIL dbgw_ready: got ready/stall %b expected 10", {dbg_ready, pipe_stall});
        end
        cyc();
        dbg_valid = 1'b0; dbg_we = 1'b0;
        shadow[3] = 32'h8C123456;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            n_checks++;
            if ({mem_we, mem_re, pipe_stall} !== 3'b100 || mem_addr !== 32'd3 || mem_wdata !== 32'h8C123456) begin
                n_fail++;
                $display("FAIL dbgw_strobe_c%0d: got we/re/stall %b addr %h data %h expected 100 3 8c123456",
                         c, {mem_we, mem_re, pipe_stall}, mem_addr, mem_wdata);
            end
            cyc();
        end
        @(negedge clk);
        n_checks++;
        if ({dbg_rvalid, mem_we} !== 2'b10) begin
            n_fail++; $display("FAIL dbgw_rvalid: got rvalid/we %b expected 10", {dbg_rvalid, mem_we});
        end
        cyc();
        @(negedge clk);
        n_checks++;
        if (dbg_rvalid !== 1'b0) begin n_fail++; $display("FAIL dbgw_pulse: rvalid still %b expected 0", dbg_rvalid); end
        cyc();
    endtask

    task automatic dbg_access(input bit we, input int addr, input logic [31:0] data);
        logic [31:0] exp;
        bit got;
        dbg_valid = 1'b1; dbg_we = we; dbg_addr = 32'(addr); dbg_wdata = data;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (dbg_ready) got = 1'b1;
            cyc();
        end
        dbg_valid = 1'b0; dbg_we = 1'b0;
        if (!got) begin
            n_checks++; n_fail++; $display("FAIL dbg_grant_timeout: addr %0d never granted", addr);
            return;
        end
        if (we) shadow[addr] = data;
        else dbg_exp_q.push_back(shadow[addr]);
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (dbg_rvalid) begin
                got = 1'b1;
                if (!we) begin
                    exp = dbg_exp_q.pop_front();
                    n_checks++;
                    if (dbg_rdata !== exp) begin
                        n_fail++; $display("FAIL dbg_read_%0d: got %h expected %h", addr, dbg_rdata, exp);
                    end
                end
            end
            cyc();
        end
        if (!got) begin n_checks++; n_fail++; $display("FAIL dbg_rvalid_timeout: addr %0d", addr); end
    endtask

    task automatic pipe_access(input bit re, input bit we, input int addr, input logic [31:0] data,
                               input bit chk_timing);
        logic [31:0] exp;
        int stall_cnt;
        bit got;
        pipe_re = re; pipe_we = we; pipe_addr = 32'(addr); pipe_wdata = data;
        if (we) shadow[addr] = data;
        else pipe_exp_q.push_back(shadow[addr]);
        stall_cnt = 0; got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (pipe_done) begin
                got = 1'b1;
                if (chk_timing) begin
                    n_checks++;
                    if (k != LAT + 1 || stall_cnt != LAT + 1 || pipe_stall !== 1'b0) begin
                        n_fail++;
                        $display("FAIL pipe_timing_%0d: done at %0d stalls %0d expected %0d %0d",
                                 addr, k, stall_cnt, LAT + 1, LAT + 1);
                    end
                end
                if (!we) begin
                    exp = pipe_exp_q.pop_front();
                    n_checks++;
                    if (pipe_rdata !== exp) begin
                        n_fail++; $display("FAIL pipe_read_%0d: got %h expected %h", addr, pipe_rdata, exp);
                    end
                end
            end else if (pipe_stall) begin
                stall_cnt++;
            end
            cyc();
        end
        pipe_re = 1'b0; pipe_we = 1'b0;
        if (!got) begin n_checks++; n_fail++; $display("FAIL pipe_done_timeout: addr %0d", addr); end
    endtask

    task automatic test_preload_sweep();
        logic [31:0] pre [0:8];
        pre[0] = 32'h002300AA; pre[1] = 32'h10654321; pre[2] = 32'h20A1B2C3;
        pre[3] = 32'h3C0FFEE0; pre[4] = 32'h4DEADBEE; pre[5] = 32'h5A5A5A5A;
        pre[6] = 32'h6BADF00D; pre[7] = 32'h7FEDCBA9; pre[8] = 32'h12012345;
        for (int i = 0; i < 9; i++) dbg_access(1'b1, i, pre[i]);
        dbg_access(1'b0, 6, 32'h0);
        for (int i = 0; i < 9; i++) pipe_access(1'b1, 1'b0, i, 32'h0, 1'b1);
        repeat (3) cyc();
        @(negedge clk);
        n_checks++;
        if (pipe_rdata !== pre[8]) begin
            n_fail++; $display("FAIL pipe_rdata_hold: got %h expected %h", pipe_rdata, pre[8]);
        end
        cyc();
    endtask

    task automatic test_we_wins();
        bit got;
        pipe_re = 1'b1; pipe_we = 1'b1; pipe_addr = 32'd5; pipe_wdata = 32'hAD654321;
        shadow[5] = 32'hAD654321;
        cyc();
        @(negedge clk);
        n_checks++;
        if ({mem_we, mem_re} !== 2'b10 || mem_addr !== 32'd5 || mem_wdata !== 32'hAD654321) begin
            n_fail++;
            $display("FAIL we_wins: got we/re %b addr %h data %h expected 10 5 ad654321",
                     {mem_we, mem_re}, mem_addr, mem_wdata);
        end
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            if (pipe_done) got = 1'b1;
            cyc();
        end
        pipe_re = 1'b0; pipe_we = 1'b0;
        if (!got) begin n_checks++; n_fail++; $display("FAIL we_wins_timeout: no pipe_done"); end
        pipe_access(1'b1, 1'b0, 5, 32'h0, 1'b1);
    endtask

    task automatic test_starve();
        logic [31:0] exp;
        int grants, at_ready, stall_bad, paddr;
        bit busy, fin;
        grants = 0; at_ready = -1; stall_bad = 0; paddr = 0; busy = 1'b0; fin = 1'b0;
        dbg_valid = 1'b1; dbg_we = 1'b0; dbg_addr = 32'd2;
        pipe_re = 1'b1; pipe_we = 1'b0; pipe_addr = 32'd0;
        pipe_exp_q.push_back(shadow[0]);
        for (int c = 0; c < 80 && !fin; c++) begin
            bit saw_ready, saw_done;
            @(negedge clk);
            saw_ready = dbg_ready;
            saw_done  = pipe_done;
            if (dbg_ready) begin
                at_ready = grants; busy = 1'b1; dbg_exp_q.push_back(shadow[2]);
            end
            if (busy && !pipe_stall) stall_bad++;
            if (dbg_rvalid) begin
                exp = dbg_exp_q.pop_front();
                busy = 1'b0;
                n_checks++;
                if (dbg_rdata !== exp) begin n_fail++; $display("FAIL starve_dbg_rdata: got %h expected %h", dbg_rdata, exp); end
            end
            if (pipe_done) begin
                exp = pipe_exp_q.pop_front();
                grants++;
                n_checks++;
                if (pipe_rdata !== exp) begin n_fail++; $display("FAIL starve_pipe_rdata: got %h expected %h", pipe_rdata, exp); end
                if (at_ready >= 0 && !busy) fin = 1'b1;
            end
            cyc();
            if (saw_ready) dbg_valid = 1'b0;
            if (saw_done && !fin) begin
                paddr++;
                pipe_addr = 32'(paddr);
                pipe_exp_q.push_back(shadow[paddr]);
            end
        end
        pipe_re = 1'b0; dbg_valid = 1'b0;
        n_checks++;
        if (!fin) begin n_fail++; $display("FAIL starve_timeout: grants %0d at_ready %0d", grants, at_ready); end
        n_checks++;
        if (at_ready != 4) begin n_fail++; $display("FAIL starve_grants: got %0d expected 4", at_ready); end
        n_checks++;
        if (stall_bad != 0) begin n_fail++; $display("FAIL starve_stall: got %0d unstalled cycles expected 0", stall_bad); end
        n_checks++;
        if (grants != 5) begin n_fail++; $display("FAIL starve_resume: got %0d pipe grants expected 5", grants); end
        cyc();
    endtask

    task automatic test_latency();
        int n1, n2, n15, d1, d2, d15;
        n1 = 0; n2 = 0; n15 = 0; d1 = -1; d2 = -1; d15 = -1;
        pipe_re = 1'b0; pipe_we = 1'b0; dbg_valid = 1'b0;
        repeat (20) cyc();
        pipe_re = 1'b1; pipe_addr = 32'd7;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (mem_re) n2++;
            if (l1_mem_re) n1++;
            if (l15_mem_re) n15++;
            if (pipe_done) d2 = c;
            if (l1_done) d1 = c;
            if (l15_done) d15 = c;
            cyc();
            if (c == 0) pipe_re = 1'b0;
        end
        n_checks++;
        if (n1 != 1 || d1 != 2) begin n_fail++; $display("FAIL lat1: strobes %0d done %0d expected 1 2", n1, d1); end
        n_checks++;
        if (n2 != 2 || d2 != 3) begin n_fail++; $display("FAIL lat2: strobes %0d done %0d expected 2 3", n2, d2); end
        n_checks++;
        if (n15 != 15 || d15 != 16) begin n_fail++; $display("FAIL lat15: strobes %0d done %0d expected 15 16", n15, d15); end
        n_checks++;
        if (l1_rdata !== ~32'd7 || l15_rdata !== ~32'd7) begin
            n_fail++; $display("FAIL lat_rdata: got %h %h expected %h", l1_rdata, l15_rdata, ~32'd7);
        end
        n_checks++;
        if (pipe_rdata !== shadow[7]) begin n_fail++; $display("FAIL lat2_rdata: got %h expected %h", pipe_rdata, shadow[7]); end
    endtask

    task automatic test_reset_mid();
        int bad;
        bad = 0;
        pipe_re = 1'b1; pipe_we = 1'b0; pipe_addr = 32'd4;
        cyc();
        @(negedge clk);
        n_checks++;
        if (mem_re !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy: mem_re %b expected 1", mem_re); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({mem_re, mem_we, pipe_stall, pipe_done} !== 4'b0 || mem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL rstmid_drop: got re/we/stall/done %b addr %h expected 0000 0",
                     {mem_re, mem_we, pipe_stall, pipe_done}, mem_addr);
        end
        pipe_re = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if ({mem_re, mem_we, pipe_done, dbg_rvalid, dbg_ready, pipe_stall} !== 6'b0) bad++;
            cyc();
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL rstmid_idle: got %0d active cycles expected 0", bad); end
        pipe_access(1'b1, 1'b0, 4, 32'h0, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0; pipe_re = 1'b0; pipe_we = 1'b0; pipe_addr = '0; pipe_wdata = '0;
        dbg_valid = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        test_reset();
        test_dbg_write();
        test_preload_sweep();
        test_we_wins();
        test_starve();
        test_latency();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
